tug_referee: RTL and testbench
==============================

// Module: tug_referee
// PURPOSE
// - Consumer end of the push-button-latch interface in the Tug of War game.
// - Samples the latch's push/tie/right outputs and moves a one-hot rope marker on the LED bar.
// - Issues the latch's clear pulse and declares a winner when the marker reaches either end.
// - Sits between the button latch and the LED/score display logic.
// PARAMETERS
// - NUM_LEDS     7  LED bar width; odd, >= 3; centre index = NUM_LEDS/2
// - HOLD_CYCLES  4  cycles after a clear during which push is ignored (latch settle); >= 1
// PORTS
// - clk           in   1         system clock, rising edge
// - rst           in   1         reset; asynchronous, active-low
// - push          in   1         latch: a button event is captured (level, held until clear)
// - tie           in   1         latch: both buttons pressed together; valid when push=1
// - right         in   1         latch: right player pressed first; valid when push=1 and tie=0
// - new_game      in   1         synchronous restart request, level-sampled
// - clear         out  1         to latch: flush the captured event
// - leds          out  NUM_LEDS  one-hot marker; leds[NUM_LEDS-1] = right end, leds[0] = left end
// - winner_valid  out  1         a player has won; held until new_game or reset
// - winner_right  out  1         1 = right won, 0 = left won; meaningful only when winner_valid=1
// - move_count    out  8         number of non-tie moves this game, saturates at 255
// BEHAVIOUR
// - All outputs are registered.
// - Reset (rst=0, async):
//   - state=ARMED, pos=NUM_LEDS/2, leds=one-hot(centre).
//   - clear=0, winner_valid=0, winner_right=0, move_count=0.
// - States: ARMED, HOLD, WIN. hold_cnt is internal, width clog2(HOLD_CYCLES+1).
// - ARMED, push=1 sampled at edge N:
//   - Edge N updates pos: tie=1 -> unchanged; right=1 -> pos+1; else -> pos-1.
//   - At edge N, leds and move_count (non-tie only, saturating) update.
//   - clear=1 for exactly the cycle after edge N.
//   - If the new pos is 0 or NUM_LEDS-1: go to WIN; winner_valid=1, winner_right=(pos==NUM_LEDS-1).
//   - Otherwise go to HOLD with hold_cnt=HOLD_CYCLES.
// - ARMED, push=0: no change; clear=0.
// - HOLD:
//   - clear=1 only on the first cycle, 0 afterwards.
//   - push is ignored and hold_cnt decrements each cycle; at 1, return to ARMED.
//   - The next push is accepted no earlier than HOLD_CYCLES+1 edges after the accepting edge.
// - WIN: clear held 1 continuously (latch kept flushed); push, tie and right ignored; leds frozen at the end LED.
// - new_game=1 in any state (priority over a push in the same cycle):
//   - pos=centre, move_count=0, winner_valid=0, winner_right=0.
//   - clear=1 for one cycle, then enter HOLD with hold_cnt=HOLD_CYCLES.
// - pos arithmetic: range 0..NUM_LEDS-1. Leaving that range is unreachable, because a game ends at either end and WIN blocks moves.
// - tie=1 or right=1 with push=0: ignored.
// - Reset mid-HOLD or mid-WIN: immediate return to reset values; no clear pulse is generated.
// TESTING (NUM_LEDS=7, HOLD_CYCLES=4)
// 1. Release reset -> leds=7'b0001000, clear=0, winner_valid=0, move_count=0.
// 2. push=1, right=1 from edge N, held 6 cycles:
//    -> leds=7'b0010000 and move_count=1 after edge N; clear=1 for exactly 1 cycle.
//    -> No second move until edge N+5; at N+5 leds=7'b0100000.
// 3. push=1, tie=1 for 1 cycle -> clear pulses 1 cycle; leds and move_count unchanged.
// 4. Three spaced right pushes:
//    -> leds=7'b1000000, winner_valid=1, winner_right=1, clear stays 1.
//    -> A further left push leaves leds unchanged.
//    -> new_game=1 gives leds=7'b0001000, winner_valid=0, move_count=0.
// 5. Left push, then rst=0 two cycles into HOLD -> same cycle: leds=7'b0001000, clear=0, move_count=0.
// 6. push=1, right=1 and new_game=1 in the same cycle -> leds=7'b0001000, move_count=0, one clear pulse.

Source files
------------

// File: rtl/tug_referee.sv
// Tug of War referee: consumes the button latch events, walks a one-hot rope
// marker along the LED bar, pulses the latch clear and declares a winner.
module tug_referee #(
  parameter int unsigned NUM_LEDS    = 7,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                tie,
  input  logic                right,
  input  logic                new_game,
  output logic                clear,
  output logic [NUM_LEDS-1:0] leds,
  output logic                winner_valid,
  output logic                winner_right,
  output logic [7:0]          move_count
);

  localparam int unsigned PW = $clog2(NUM_LEDS);
  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

  localparam logic [PW-1:0] CENTRE    = PW'(NUM_LEDS / 2);
  localparam logic [PW-1:0] LAST      = PW'(NUM_LEDS - 1);
  localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES);
  localparam logic [NUM_LEDS-1:0] ONE = NUM_LEDS'(1);

  typedef enum logic [1:0] {ARMED, HOLD, WIN} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          clear_d, winner_valid_d, winner_right_d;
  logic [7:0]    move_count_d;
  logic [NUM_LEDS-1:0] leds_d;

  always_comb begin
    state_d        = state_q;
    pos_d          = pos_q;
    hold_cnt_d     = hold_cnt_q;
    clear_d        = 1'b0;
    winner_valid_d = winner_valid;
    winner_right_d = winner_right;
    move_count_d   = move_count;

    if (new_game) begin
      pos_d          = CENTRE;
      move_count_d   = '0;
      winner_valid_d = 1'b0;
      winner_right_d = 1'b0;
      clear_d        = 1'b1;
      state_d        = HOLD;
      hold_cnt_d     = HOLD_INIT;
    end else begin
      unique case (state_q)
        ARMED: begin
          if (push) begin
            if (!tie) begin
              pos_d = right ? pos_q + PW'(1) : pos_q - PW'(1);
              if (move_count != '1) move_count_d = move_count + 8'd1;
            end
            clear_d = 1'b1;
            if (pos_d == '0 || pos_d == LAST) begin
              state_d        = WIN;
              winner_valid_d = 1'b1;
              winner_right_d = (pos_d == LAST);
            end else begin
              state_d    = HOLD;
              hold_cnt_d = HOLD_INIT;
            end
          end
        end
        HOLD: begin
          hold_cnt_d = hold_cnt_q - CW'(1);
          if (hold_cnt_q == CW'(1)) state_d = ARMED;
        end
        WIN: begin
          // keep the latch flushed so late presses never queue up for the next game
          clear_d = 1'b1;
        end
        default: state_d = ARMED;
      endcase
    end

    leds_d = ONE << pos_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARMED;
      pos_q        <= CENTRE;
      hold_cnt_q   <= '0;
      clear        <= 1'b0;
      leds         <= ONE << CENTRE;
      winner_valid <= 1'b0;
      winner_right <= 1'b0;
      move_count   <= '0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      hold_cnt_q   <= hold_cnt_d;
      clear        <= clear_d;
      leds         <= leds_d;
      winner_valid <= winner_valid_d;
      winner_right <= winner_right_d;
      move_count   <= move_count_d;
    end
  end

endmodule

// File: tb/tb_tug_referee.sv
// Scoreboard bench for tug_referee: a game-level reference model predicts the
// outputs after every clock edge; a monitor pops and compares them.
module tb_tug_referee;
  localparam int N = 7;
  localparam int H = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic push = 1'b0, tie = 1'b0, right = 1'b0, new_game = 1'b0;
  logic clear, winner_valid, winner_right;
  logic [N-1:0] leds;
  logic [7:0] move_count;

  tug_referee #(.NUM_LEDS(N), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .push(push), .tie(tie), .right(right),
    .new_game(new_game), .clear(clear), .leds(leds),
    .winner_valid(winner_valid), .winner_right(winner_right),
    .move_count(move_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int tag;
    logic [N-1:0] leds;
    logic clear, wv, wr;
    logic [7:0] mc;
  } exp_t;
  exp_t q[$];

  int tests = 0, fails = 0;

  // game-level model: marker position, a score tally, and the edge from which
  // the referee will next listen to the latch
  int m_pos, m_mc, m_ready;
  bit m_win, m_wr, m_clr;

  function automatic void model_reset();
    m_pos = N / 2; m_mc = 0; m_ready = 0;
    m_win = 0; m_wr = 0; m_clr = 0;
  endfunction

  function automatic void model_edge(bit p, bit t, bit r, bit g, int e);
    if (g) begin
      m_pos = N / 2; m_mc = 0; m_win = 0; m_wr = 0; m_clr = 1;
      m_ready = e + H + 1;
    end else if (m_win) begin
      m_clr = 1;
    end else if (p && e >= m_ready) begin
      if (!t) begin
        m_pos = r ? m_pos + 1 : m_pos - 1;
        if (m_mc < 255) m_mc = m_mc + 1;
      end
      m_clr = 1;
      m_ready = e + H + 1;
      if (m_pos == 0 || m_pos == N - 1) begin
        m_win = 1;
        m_wr = (m_pos == N - 1);
      end
    end else begin
      m_clr = 0;
    end
  endfunction

  function automatic exp_t snap(int tag);
    exp_t x;
    x.tag  = tag;
    x.leds = N'(1 << m_pos);
    x.clear = m_clr;
    x.wv = m_win;
    x.wr = m_wr;
    x.mc = 8'(m_mc);
    return x;
  endfunction

  task automatic step(input bit p, input bit t, input bit r, input bit g);
    @(posedge clk);
    #1;
    push = p; tie = t; right = r; new_game = g;
    model_edge(p, t, r, g, cyc + 1);
    q.push_back(snap(cyc + 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic do_reset(input int low_cycles);
    @(posedge clk);
    #3;
    push = 0; tie = 0; right = 0; new_game = 0;
    model_reset();
    q.push_back(snap(cyc));
    rst = 1'b0;
    for (int i = 0; i < low_cycles; i++) begin
      @(posedge clk);
      #1;
      q.push_back(snap(cyc));
    end
    rst = 1'b1;
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
    end
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk or negedge rst);
      #2;
      while (q.size() > 0 && q[0].tag <= cyc) begin
        x = q.pop_front();
        chk("leds", int'(leds), int'(x.leds));
        chk("clear", int'(clear), int'(x.clear));
        chk("winner_valid", int'(winner_valid), int'(x.wv));
        chk("winner_right", int'(winner_right), int'(x.wr));
        chk("move_count", int'(move_count), int'(x.mc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    q.push_back(snap(cyc));

    // right held six cycles: moves at N and N+5 only
    for (int i = 0; i < 6; i++) step(1, 0, 1, 0);
    idle(5);
    // tie: clear pulse only
    step(1, 1, 0, 0);
    idle(5);
    // fresh game, three spaced right pushes to the right end
    step(0, 0, 0, 1);
    idle(5);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 1, 0);
      idle(4);
    end
    step(1, 0, 0, 0);
    idle(3);
    step(0, 0, 0, 1);
    idle(5);
    // left push then reset two cycles into HOLD
    step(1, 0, 0, 0);
    idle(2);
    do_reset(2);
    idle(2);
    // push and new_game together
    step(1, 0, 1, 1);
    idle(6);
    // alternate moves at the minimum spacing to saturate move_count
    for (int i = 0; i < 260; i++) begin
      step(1, 0, (i % 2) == 0, 0);
      idle(H);
    end
    step(0, 0, 0, 1);
    idle(6);
    // randomized play
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0)
        do_reset(1 + $urandom_range(0, 2));
      else
        step($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
    end
    idle(2);
    repeat (2) @(posedge clk);
    #3;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
